// File: rtl/tour_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module : tour_pkg
// Brief  : Shared types and constants for the knight's-tour command sequencer.
// Rev    : 1.0
// ============================================================================
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VERT  = 3'd1,
        HOLDV = 3'd2,
        HORZ  = 3'd3,
        HOLDH = 3'd4
    } tour_state_e;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    localparam logic [7:0] RESP_POS = 8'hA5;
    localparam logic [7:0] RESP_ACK = 8'h5A;

    // Signed 3-bit knight offsets, entry [b] belongs to move bit b (b7 first).
    localparam logic [7:0][2:0] MV_DX = {
        3'b010, 3'b010, 3'b001, 3'b111, 3'b110, 3'b110, 3'b111, 3'b001
    };
    localparam logic [7:0][2:0] MV_DY = {
        3'b001, 3'b111, 3'b110, 3'b110, 3'b111, 3'b001, 3'b010, 3'b010
    };

endpackage : tour_pkg
`default_nettype wire

// File: rtl/tour_cmd_if.sv
`default_nettype none
// ============================================================================
// Module : tour_cmd_if
// Brief  : Command/handshake bundle between sequencer and command processor.
// Rev    : 1.0
// ============================================================================
interface tour_cmd_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output cmd_rdy,
        output resp,
        input  clr_cmd_rdy,
        input  send_resp
    );

    modport slave (
        input  cmd,
        input  cmd_rdy,
        input  resp,
        output clr_cmd_rdy,
        output send_resp
    );
endinterface : tour_cmd_if
`default_nettype wire

// File: rtl/tour_cmd_move_decode.sv
`default_nettype none
// ============================================================================
// Module : move_decode
// Brief  : One-hot knight move to signed (dx,dy); highest set bit wins.
// Rev    : 1.0
// ============================================================================
module move_decode
    import tour_pkg::*;
(
    input  wire logic [7:0]        i_move,
    output logic signed [2:0]      o_dx,
    output logic signed [2:0]      o_dy
);

    // Ascending scan so that the last (highest) set bit overrides lower ones.
    always_comb begin
        o_dx = '0;
        o_dy = '0;
        for (int i = 0; i < 8; i++) begin
            if (i_move[i]) begin
                o_dx = MV_DX[i];
                o_dy = MV_DY[i];
            end
        end
    end

endmodule : move_decode
`default_nettype wire

// File: rtl/tour_cmd.sv
`default_nettype none
// ============================================================================
// Module : tour_cmd
// Brief  : Reads solved knight moves and issues vertical/horizontal commands;
//          passes UART commands straight through while idle.
// Rev    : 1.0
// ============================================================================
module tour_cmd
    import tour_pkg::*;
#(
    parameter int BOARD_SIZE     = 5,
    parameter int MOVE_REG_WIDTH = $clog2(BOARD_SIZE**2-1)
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      start_tour,
    output logic [MOVE_REG_WIDTH-1:0]      mv_indx,
    input  wire logic [7:0]                move,
    input  wire logic [15:0]               cmd_UART,
    input  wire logic                      cmd_rdy_UART,
    output logic                           clr_cmd_rdy_UART,
    tour_cmd_if.master                     cp
);

    localparam logic [MOVE_REG_WIDTH-1:0] c_last_indx = MOVE_REG_WIDTH'(BOARD_SIZE**2-2);

    tour_state_e                 r_state;
    logic [MOVE_REG_WIDTH-1:0]   r_mv_indx;
    logic signed [2:0]           w_dx;
    logic signed [2:0]           w_dy;
    logic [2:0]                  w_dx_mag;
    logic [2:0]                  w_dy_mag;
    logic [15:0]                 w_vert_cmd;
    logic [15:0]                 w_horz_cmd;
    logic                        w_last;

    move_decode u_move_decode (
        .i_move (move),
        .o_dx   (w_dx),
        .o_dy   (w_dy)
    );

    assign w_dx_mag   = w_dx[2] ? 3'(-w_dx) : w_dx;
    assign w_dy_mag   = w_dy[2] ? 3'(-w_dy) : w_dy;
    assign w_vert_cmd = {OP_MOVE,    (w_dy[2] ? HDG_S : HDG_N), 1'b0, w_dy_mag};
    assign w_horz_cmd = {OP_FANFARE, (w_dx[2] ? HDG_W : HDG_E), 1'b0, w_dx_mag};
    assign w_last     = (r_mv_indx == c_last_indx);
    assign mv_indx    = r_mv_indx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mv_indx <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_tour) begin
                    r_mv_indx <= '0;
                    r_state   <= VERT;
                end
                VERT:  if (cp.clr_cmd_rdy) r_state <= HOLDV;
                HOLDV: if (cp.send_resp)   r_state <= HORZ;
                HORZ:  if (cp.clr_cmd_rdy) r_state <= HOLDH;
                HOLDH: if (cp.send_resp) begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_mv_indx <= r_mv_indx + MOVE_REG_WIDTH'(1);
                        r_state   <= VERT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The final acknowledge flips to RESP_POS in the same cycle the UART samples it.
    always_comb begin
        cp.cmd           = cmd_UART;
        cp.cmd_rdy       = cmd_rdy_UART;
        cp.resp          = RESP_ACK;
        clr_cmd_rdy_UART = 1'b0;
        case (r_state)
            IDLE: begin
                clr_cmd_rdy_UART = cp.clr_cmd_rdy;
                cp.resp          = RESP_POS;
            end
            VERT: begin
                cp.cmd     = w_vert_cmd;
                cp.cmd_rdy = 1'b1;
            end
            HOLDV: begin
                cp.cmd     = w_vert_cmd;
                cp.cmd_rdy = 1'b0;
            end
            HORZ: begin
                cp.cmd     = w_horz_cmd;
                cp.cmd_rdy = 1'b1;
            end
            HOLDH: begin
                cp.cmd     = w_horz_cmd;
                cp.cmd_rdy = 1'b0;
                if (cp.send_resp && w_last) cp.resp = RESP_POS;
            end
            default: begin
                cp.cmd_rdy = 1'b0;
            end
        endcase
    end

endmodule : tour_cmd
`default_nettype wire

// File: tb/tb_tour_cmd.sv
`default_nettype none
// ============================================================================
// Module : tb_tour_cmd
// Brief  : Self-checking bench for tour_cmd (pass-through, legs, full tour).
// Rev    : 1.0
// ============================================================================
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [4:0]  mv_indx;
    logic [7:0]  move;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [7:0]  tour_moves [32];

    int checks   = 0;
    int failures = 0;
    int rises    = 0;
    logic prev_rdy = 1'b0;
    logic in_tour  = 1'b0;

    int DXT [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int DYT [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    typedef struct {
        logic [15:0] cu;
        logic        ru;
        logic        clr;
        logic [15:0] ecmd;
        logic        erdy;
        logic        eclr;
        logic [7:0]  eresp;
    } vec_t;

    vec_t        vt [5];
    logic [15:0] exp_cmd  [48];
    logic [15:0] exp_mask [48];

    tour_cmd_if bus ();

    tour_cmd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .mv_indx          (mv_indx),
        .move             (move),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cp               (bus)
    );

    assign move = tour_moves[mv_indx];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_tour && bus.cmd_rdy && !prev_rdy) rises++;
        prev_rdy = bus.cmd_rdy;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference legs computed from the move table; zero offsets leave heading unchecked.
    task automatic ref_legs(input logic [7:0] m, output logic [15:0] v, output logic [15:0] vm,
                            output logic [15:0] h, output logic [15:0] hm);
        int dx = 0;
        int dy = 0;
        int ax;
        int ay;
        for (int b = 7; b >= 0; b--) begin
            if (m[b]) begin
                dx = DXT[b];
                dy = DYT[b];
                break;
            end
        end
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        v  = {4'h2, ((dy < 0) ? 8'h7F : 8'h00), 4'(ay)};
        h  = {4'h3, ((dx < 0) ? 8'h3F : 8'hBF), 4'(ax)};
        vm = (dy == 0) ? 16'hF00F : 16'hFFFF;
        hm = (dx == 0) ? 16'hF00F : 16'hFFFF;
    endtask

    initial begin
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        for (int i = 0; i < 32; i++) tour_moves[i] = 8'h00;

        vt[0] = '{16'h2004, 1'b1, 1'b1, 16'h2004, 1'b1, 1'b1, 8'hA5};
        vt[1] = '{16'h3BF1, 1'b0, 1'b0, 16'h3BF1, 1'b0, 1'b0, 8'hA5};
        vt[2] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 8'hA5};
        vt[3] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 8'hA5};
        vt[4] = '{16'hA55A, 1'b1, 1'b1, 16'hA55A, 1'b1, 1'b1, 8'hA5};

        // Reset state
        cmd_UART = 16'h1357;
        #3;
        chk("rst_mv_indx", 32'(mv_indx), 32'd0);
        chk("rst_resp", 32'(bus.resp), 32'hA5);
        chk("rst_cmd", 32'(bus.cmd), 32'h1357);
        chk("rst_rdy", 32'(bus.cmd_rdy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // IDLE pass-through table
        for (int i = 0; i < 5; i++) begin
            cmd_UART = vt[i].cu;
            cmd_rdy_UART = vt[i].ru;
            bus.clr_cmd_rdy = vt[i].clr;
            #1;
            chk("idle_cmd", 32'(bus.cmd), 32'(vt[i].ecmd));
            chk("idle_rdy", 32'(bus.cmd_rdy), 32'(vt[i].erdy));
            chk("idle_clr", 32'(clr_cmd_rdy_UART), 32'(vt[i].eclr));
            chk("idle_resp", 32'(bus.resp), 32'(vt[i].eresp));
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] cu;
            logic ru;
            logic cl;
            cu = 16'($urandom);
            ru = 1'($urandom);
            cl = 1'($urandom);
            cmd_UART = cu;
            cmd_rdy_UART = ru;
            bus.clr_cmd_rdy = cl;
            #1;
            chk("idle_rand_cmd", 32'(bus.cmd), 32'(cu));
            chk("idle_rand_rdy", 32'(bus.cmd_rdy), 32'(ru));
            chk("idle_rand_clr", 32'(clr_cmd_rdy_UART), 32'(cl));
            tick();
        end
        bus.clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
        cmd_UART = 16'h1234;

        // Hand sequence: moves 0x01 and 0x08, ignored events, mid-tour reset
        tour_moves[0] = 8'h01;
        tour_moves[1] = 8'h08;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        chk("v0_cmd", 32'(bus.cmd), 32'h2002);
        chk("v0_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("v0_mv", 32'(mv_indx), 32'd0);
        chk("v0_resp", 32'(bus.resp), 32'h5A);
        start_tour = 1'b1;
        cmd_rdy_UART = 1'b1;
        bus.send_resp = 1'b1;
        tick();
        start_tour = 1'b0;
        bus.send_resp = 1'b0;
        chk("stray_cmd", 32'(bus.cmd), 32'h2002);
        chk("stray_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("stray_mv", 32'(mv_indx), 32'd0);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("tour_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
        tick();
        chk("holdv_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("holdv_cmd", 32'(bus.cmd), 32'h2002);
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("holdv_clr_ignored", 32'(bus.cmd_rdy), 32'd0);
        bus.send_resp = 1'b1;
        #1;
        chk("holdv_resp", 32'(bus.resp), 32'h5A);
        tick();
        bus.send_resp = 1'b0;
        chk("h0_cmd", 32'(bus.cmd), 32'h3BF1);
        chk("h0_rdy", 32'(bus.cmd_rdy), 32'd1);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b1;
        #1;
        chk("holdh_resp", 32'(bus.resp), 32'h5A);
        tick();
        bus.send_resp = 1'b0;
        chk("v1_mv", 32'(mv_indx), 32'd1);
        chk("v1_cmd", 32'(bus.cmd), 32'h27F1);
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0;
        chk("both_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("both_cmd", 32'(bus.cmd), 32'h27F1);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        chk("h1_cmd", 32'(bus.cmd), 32'h33F2);
        chk("h1_rdy", 32'(bus.cmd_rdy), 32'd1);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("holdh_cmd", 32'(bus.cmd), 32'h33F2);
        rst_n = 1'b0;
        #1;
        chk("arst_mv", 32'(mv_indx), 32'd0);
        chk("arst_cmd", 32'(bus.cmd), 32'h1234);
        chk("arst_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("arst_resp", 32'(bus.resp), 32'hA5);
        cmd_rdy_UART = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Full randomized tour against the reference legs
        for (int i = 0; i < 24; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 9)      tour_moves[i] = 8'h00;
            else if (r == 8) tour_moves[i] = 8'($urandom_range(1, 255));
            else             tour_moves[i] = 8'(1 << r);
            ref_legs(tour_moves[i], exp_cmd[2*i], exp_mask[2*i], exp_cmd[2*i+1], exp_mask[2*i+1]);
        end
        in_tour = 1'b1;
        rises = 0;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int k = 0; k < 48; k++) begin
            int n = 0;
            while (!bus.cmd_rdy && n < 20) begin
                tick();
                n++;
            end
            chk("tour_rdy_wait", 32'(bus.cmd_rdy), 32'd1);
            chk("tour_cmd", 32'(bus.cmd & exp_mask[k]), 32'(exp_cmd[k] & exp_mask[k]));
            chk("tour_mv", 32'(mv_indx), 32'(k / 2));
            repeat (3) tick();
            bus.clr_cmd_rdy = 1'b1;
            tick();
            bus.clr_cmd_rdy = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            bus.send_resp = 1'b1;
            #1;
            chk("tour_resp", 32'(bus.resp), (k == 47) ? 32'hA5 : 32'h5A);
            tick();
            bus.send_resp = 1'b0;
        end
        in_tour = 1'b0;
        chk("tour_rises", 32'(rises), 32'd48);
        cmd_UART = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        #1;
        chk("end_idle_cmd", 32'(bus.cmd), 32'hBEEF);
        chk("end_idle_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("end_idle_resp", 32'(bus.resp), 32'hA5);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tour_cmd
`default_nettype wire

// File: doc/tour_cmd.md
# tour_cmd

Sequencer between the knight's-tour solver and the robot's command processor. After the solver pulses `start_tour`, it reads the solved moves out one at a time by index. It turns each one-hot knight move into two orthogonal move commands: a vertical leg, then a horizontal leg. Each command is handed to the command processor with a ready/clear/response handshake. When idle, it passes UART commands and handshakes straight through, so the robot stays remotely controllable outside a tour.

## Interface
Parameters:
- `BOARD_SIZE`, default 5: board edge length.
- `MOVE_REG_WIDTH`, default `$clog2(BOARD_SIZE**2-1)`: width of the move index.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start_tour`  in  1  one-cycle pulse from the solver's `done`.
- `mv_indx`  out  MOVE_REG_WIDTH  move index to the solver.
- `move`  in  8  one-hot move returned by the solver for `mv_indx` (combinational there).
- `cmd_UART`  in  16  command from the UART wrapper.
- `cmd_rdy_UART`  in  1  UART command valid.
- `clr_cmd_rdy`  in  1  command processor consumed `cmd`.
- `send_resp`  in  1  command processor finished the current command.
- `cmd`  out  16  command to the command processor.
- `cmd_rdy`  out  1  `cmd` valid.
- `clr_cmd_rdy_UART`  out  1  consume acknowledge forwarded to the UART wrapper.
- `resp`  out  8  response byte to the UART.

## Operation
- Move encoding (dx,dy): b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1), b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1).
- Decode priority runs from the highest set bit. `move==0` decodes as 0 squares for both legs.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Vertical leg uses opcode 4'h2 (move).
  - Horizontal leg uses opcode 4'h3 (move with fanfare).
- Headings:
  - Vertical leg: north 8'h00 when dy>0, south 8'h7F when dy<0.
  - Horizontal leg: east 8'hBF when dx>0, west 8'h3F when dx<0.
- Squares field = |offset|, zero-extended to 4 bits.
- States are IDLE, VERT, HOLDV, HORZ, HOLDH.
  - IDLE: `cmd=cmd_UART`, `cmd_rdy=cmd_rdy_UART`, `clr_cmd_rdy_UART=clr_cmd_rdy`. On `start_tour`, load `mv_indx` to 0 and go to VERT.
  - VERT: drive the vertical command with `cmd_rdy=1`. On `clr_cmd_rdy`, go to HOLDV.
  - HOLDV: `cmd_rdy=0`. On `send_resp`, go to HORZ.
  - HORZ: drive the horizontal command with `cmd_rdy=1`. On `clr_cmd_rdy`, go to HOLDH.
  - HOLDH: `cmd_rdy=0`. On `send_resp`:
    - if `mv_indx==BOARD_SIZE**2-2`, go to IDLE;
    - else increment `mv_indx` and go to VERT.
- Outside IDLE:
  - `cmd_rdy_UART` is ignored.
  - `clr_cmd_rdy_UART=0`.
  - `cmd` holds the current leg's command in the HOLD states as well.
- `resp`:
  - 8'hA5 in IDLE and in the cycle of the final HOLDH `send_resp`.
  - 8'h5A otherwise. The UART samples `resp` on `send_resp`.

## Timing
- Reset values: state IDLE, `mv_indx` 0.
  - Outputs then follow the IDLE pass-through: `cmd=cmd_UART`, `cmd_rdy=cmd_rdy_UART`, `clr_cmd_rdy_UART=clr_cmd_rdy`, `resp` 8'hA5.
- `mv_indx` is registered. `move` is assumed settled within the same cycle, so `cmd` is valid one cycle after `start_tour` or after an index increment.
- `cmd` and `cmd_rdy` are combinational from state and `move`. There are no bubbles beyond the handshake.
- Ignored events:
  - `start_tour` outside IDLE.
  - `send_resp` in VERT or HORZ.
  - `clr_cmd_rdy` in HOLDV or HOLDH.
- `clr_cmd_rdy` and `send_resp` in the same cycle: only the one valid for the current state acts.
- A full tour issues exactly 2·(BOARD_SIZE²−1) commands; for the default that is 48.
- Asserting `rst_n` low mid-tour immediately returns to IDLE pass-through. There is no resume.

## Structure
- `tour_pkg` holds:
  - the state typedef;
  - opcode constants `OP_MOVE`, `OP_FANFARE`;
  - heading constants `HDG_N`, `HDG_S`, `HDG_E`, `HDG_W`;
  - response constants `RESP_POS`, `RESP_ACK`;
  - move-bit offsets shared with the solver.
- One combinational sub-module, `move_decode`, maps `move` to signed dx and dy (3 bits each). It is reusable by the solver's backup path.

## Test plan
- Reset, then `cmd_rdy_UART=1`, `cmd_UART=16'h2004` → `cmd=16'h2004`, `cmd_rdy=1`; `clr_cmd_rdy` appears on `clr_cmd_rdy_UART` in the same cycle.
- `start_tour` with `move=8'h01` → `cmd=16'h2002` (north, 2 squares) and `cmd_rdy=1`. After `clr_cmd_rdy` then `send_resp` → `cmd=16'h3BF1` (east, 1 square) and `resp=8'h5A`.
- `move=8'h08` → `16'h27F1` (south, 1 square), then `16'h33F2` (west, 2 squares).
- Full 24-move tour with the responder acking every command after 3 cycles → exactly 48 `cmd_rdy` rises, `mv_indx` stepping 0..23, final `resp=8'hA5`, and a return to IDLE.
- Mid-tour: `start_tour`, `cmd_rdy_UART` and stray `send_resp` in VERT → no state change. Then `rst_n=0` in HOLDH → immediate IDLE with `mv_indx=0`.
